i2c_master_fsm: RTL and testbench

Upstream control stage of the I2C master datapath. Sequences START / address / data / ACK / STOP / repeated-START phases and generates SCL. Drives the datapath's one-hot phase strobes, bit-phase counter and repeat-start countdown. Consumes the datapath's bit/ACK counter to detect byte boundaries.

---
 rtl/i2c_master_fsm.sv | 190 +++++++++++++++++++
 tb/tb_i2c_master_fsm.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_fsm.sv
// -----------------------------------------------------------------------------
// i2c_master_fsm
// Control stage of the I2C master datapath. Sequences the bus phases
// (START, address, data, ACK, STOP, repeated START), generates SCL and
// drives the datapath's one-hot phase strobes, bit-phase counter and
// repeat-start countdown. Byte boundaries come from the datapath's
// bit/ACK counter.
//
// Ports
//   i2c_core_clock_i        core clock
//   reset_bit_n_i           asynchronous active-low reset
//   enable_i                request a transaction (sampled in IDLE)
//   rw_bit_i, length_i      direction and byte count, latched at START/REPEAT_START
//   repeat_start_i          end of transfer: 1 = repeated START, 0 = STOP
//   prescaler_i             half SCL period P in core clocks (2..128), latched at START
//   sda_i                   SDA sample (slave ACK/NACK)
//   counter_data_ack_i      datapath bit/ACK counter
//   *_cnt_o                 one-hot phase strobes
//   counter_detect_edge_o   bit-phase counter
//   counter_state_done_time_repeat_start_o  repeat-start countdown
//   ack_bit_o               master ACK/NACK driven for read bytes
//   scl_o, busy_o           bus clock and activity flag
//   data_req_o, rd_valid_o, done_o  single-clock event pulses
//   nack_o                  sticky slave NACK, cleared at next START
//
// state        | meaning
// IDLE         | bus released, waiting for enable_i
// START        | SCL high while the datapath pulls SDA low, P clocks
// WRITE_ADDR   | shifting out the 7-bit address + R/W bit
// READ_ACK     | sampling the slave ACK
// WRITE_DATA   | shifting out a write byte
// READ_DATA    | shifting in a read byte
// WRITE_ACK    | master drives ACK/NACK for a read byte
// STOP         | final SCL period before releasing the bus
// REPEAT_START | SCL low then high while SDA falls, 2P clocks
// -----------------------------------------------------------------------------
module i2c_master_fsm (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_n_i,
    input  logic       enable_i,
    input  logic       rw_bit_i,
    input  logic [7:0] length_i,
    input  logic       repeat_start_i,
    input  logic [7:0] prescaler_i,
    input  logic       sda_i,
    input  logic [7:0] counter_data_ack_i,
    output logic       start_cnt_o,
    output logic       write_addr_cnt_o,
    output logic       write_data_cnt_o,
    output logic       read_data_cnt_o,
    output logic       write_ack_cnt_o,
    output logic       read_ack_cnt_o,
    output logic       stop_cnt_o,
    output logic       repeat_start_cnt_o,
    output logic [7:0] counter_detect_edge_o,
    output logic [7:0] counter_state_done_time_repeat_start_o,
    output logic       ack_bit_o,
    output logic       scl_o,
    output logic       busy_o,
    output logic       data_req_o,
    output logic       rd_valid_o,
    output logic       nack_o,
    output logic       done_o
);

    typedef enum logic [3:0] {
        IDLE, START, WRITE_ADDR, READ_ACK, WRITE_DATA,
        READ_DATA, WRITE_ACK, STOP, REPEAT_START
    } state_t;

    state_t     state, state_nxt, end_state;
    logic [7:0] cnt, countdown, p_reg, bytes_left, load_len;
    logic [7:0] p_m1, two_p_m1, two_p_m2;
    logic       rw, after_addr, nack, data_req, rd_valid, done;
    logic       timed, period_end, dec_bytes;

    // P <= 128, so 2P-1 and 2P-2 always fit in 8 bits (P=128 wraps 0-1 to 255)
    assign p_m1     = p_reg - 8'd1;
    assign two_p_m1 = {p_reg[6:0], 1'b0} - 8'd1;
    assign two_p_m2 = {p_reg[6:0], 1'b0} - 8'd2;

    assign timed      = state inside {WRITE_ADDR, READ_ACK, WRITE_DATA,
                                      READ_DATA, WRITE_ACK, STOP};
    assign period_end = timed && (cnt == two_p_m1);
    assign end_state  = repeat_start_i ? REPEAT_START : STOP;
    // a zero-length read still has to clock in one byte
    assign load_len   = (rw_bit_i && length_i == 8'd0) ? 8'd1 : length_i;
    assign dec_bytes  = period_end &&
                        ((state == READ_ACK && !sda_i && !after_addr) ||
                         (state == WRITE_ACK));

    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
        if (!reset_bit_n_i) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (enable_i) state_nxt = START;
            START:        if (cnt == p_m1) state_nxt = WRITE_ADDR;
            WRITE_ADDR:   if (period_end && counter_data_ack_i == 8'd2) state_nxt = READ_ACK;
            READ_ACK:
                if (period_end) begin
                    if (sda_i)               state_nxt = STOP;
                    else if (after_addr)     state_nxt = rw ? READ_DATA :
                                                         (bytes_left != 8'd0 ? WRITE_DATA : end_state);
                    else                     state_nxt = (bytes_left > 8'd1) ? WRITE_DATA : end_state;
                end
            WRITE_DATA:   if (period_end && counter_data_ack_i == 8'd2) state_nxt = READ_ACK;
            READ_DATA:    if (period_end && counter_data_ack_i == 8'd2) state_nxt = WRITE_ACK;
            WRITE_ACK:    if (period_end) state_nxt = (bytes_left > 8'd1) ? READ_DATA : end_state;
            STOP:         if (period_end) state_nxt = IDLE;
            REPEAT_START: if (countdown == 8'd0) state_nxt = WRITE_ADDR;
            default:      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
        if (!reset_bit_n_i) begin
            cnt        <= 8'd0;
            countdown  <= 8'd0;
            p_reg      <= 8'd0;
            bytes_left <= 8'd0;
            rw         <= 1'b0;
            after_addr <= 1'b0;
            nack       <= 1'b0;
            data_req   <= 1'b0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (state_nxt != state)  cnt <= 8'd0;
            else if (state == START) cnt <= cnt + 8'd1;
            else if (timed)          cnt <= period_end ? 8'd0 : cnt + 8'd1;
            else                     cnt <= 8'd0;

            if (state == WRITE_ADDR)      after_addr <= 1'b1;
            else if (state == WRITE_DATA) after_addr <= 1'b0;

            if (dec_bytes) bytes_left <= bytes_left - 8'd1;

            if (state == IDLE && state_nxt == START) begin
                p_reg      <= prescaler_i;
                rw         <= rw_bit_i;
                bytes_left <= load_len;
                nack       <= 1'b0;
            end

            // the reload must win over a WRITE_ACK/READ_ACK decrement on the same clock
            if (state_nxt == REPEAT_START && state != REPEAT_START) begin
                countdown  <= two_p_m1;
                rw         <= rw_bit_i;
                bytes_left <= load_len;
            end else if (state == REPEAT_START && countdown != 8'd0) begin
                countdown  <= countdown - 8'd1;
            end

            if (state == READ_ACK && period_end && sda_i) nack <= 1'b1;

            data_req <= (state_nxt == WRITE_DATA) && (state != WRITE_DATA);
            rd_valid <= (state == READ_DATA) && (state_nxt == WRITE_ACK);
            done     <= (state == STOP) && (state_nxt == IDLE);
        end
    end

    always_comb begin
        start_cnt_o        = (state == START);
        write_addr_cnt_o   = (state == WRITE_ADDR);
        write_data_cnt_o   = (state == WRITE_DATA);
        read_data_cnt_o    = (state == READ_DATA);
        write_ack_cnt_o    = (state == WRITE_ACK);
        read_ack_cnt_o     = (state == READ_ACK);
        stop_cnt_o         = (state == STOP);
        repeat_start_cnt_o = (state == REPEAT_START);
        busy_o             = (state != IDLE);
        ack_bit_o          = (state == WRITE_ACK) && (bytes_left <= 8'd1);
        counter_detect_edge_o                  = cnt;
        counter_state_done_time_repeat_start_o = countdown;
        data_req_o         = data_req;
        rd_valid_o         = rd_valid;
        nack_o             = nack;
        done_o             = done;
        scl_o              = 1'b1;
        if (timed && cnt >= p_m1 && cnt <= two_p_m2)
            scl_o = 1'b0;
        else if (state == REPEAT_START && countdown >= p_reg)
            scl_o = 1'b0;
    end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// -----------------------------------------------------------------------------
// tb_i2c_master_fsm
// Drives transactions into i2c_master_fsm with a small datapath model for the
// bit/ACK counter. A negedge monitor collects phase changes and event counts;
// each test pushes its expected phase sequence when it starts the transfer and
// pops/compares against the observed queue once the transfer completes.
// -----------------------------------------------------------------------------
module tb_i2c_master_fsm;

    localparam logic [7:0] V_IDLE  = 8'h00, V_START = 8'h80, V_WADDR = 8'h40,
                           V_RACK  = 8'h20, V_WDATA = 8'h10, V_RDATA = 8'h08,
                           V_WACK  = 8'h04, V_STOP  = 8'h02, V_RS    = 8'h01;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       enable = 1'b0, rw = 1'b0, rs = 1'b0, sda = 1'b0;
    logic [7:0] length = 8'd0, prescaler = 8'd4, dp_cnt;
    logic       start_s, waddr_s, wdata_s, rdata_s, wack_s, rack_s, stop_s, rs_s;
    logic [7:0] cnt, cd;
    logic       ack_bit, scl, busy, dreq, rdv, nack, done;
    logic [7:0] vec;

    int p_cur = 4;
    int n_cmp = 0, n_fail = 0;

    logic [7:0] prev_vec = 8'h00;
    logic       prev_scl = 1'b1;
    int n_rise, n_busy, n_start, n_dreq, n_dreq_bad, n_rdv, n_rdv_bad, n_done, n_multi;
    int waddr_rs_cnt;
    logic [7:0] obs_phase[$], exp_phase[$];
    logic       ack_q[$];
    logic [8:0] rs_obs[$];

    always #5 clk = ~clk;

    i2c_master_fsm dut (
        .i2c_core_clock_i(clk), .reset_bit_n_i(rst_n), .enable_i(enable),
        .rw_bit_i(rw), .length_i(length), .repeat_start_i(rs),
        .prescaler_i(prescaler), .sda_i(sda), .counter_data_ack_i(dp_cnt),
        .start_cnt_o(start_s), .write_addr_cnt_o(waddr_s), .write_data_cnt_o(wdata_s),
        .read_data_cnt_o(rdata_s), .write_ack_cnt_o(wack_s), .read_ack_cnt_o(rack_s),
        .stop_cnt_o(stop_s), .repeat_start_cnt_o(rs_s),
        .counter_detect_edge_o(cnt), .counter_state_done_time_repeat_start_o(cd),
        .ack_bit_o(ack_bit), .scl_o(scl), .busy_o(busy), .data_req_o(dreq),
        .rd_valid_o(rdv), .nack_o(nack), .done_o(done)
    );

    assign vec = {start_s, waddr_s, rack_s, wdata_s, rdata_s, wack_s, stop_s, rs_s};

    // Datapath bit/ACK counter: 9 on entry to a shift phase, one step per bit period.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          dp_cnt <= 8'd9;
        else if (!(waddr_s | wdata_s | rdata_s)) dp_cnt <= 8'd9;
        else if (int'(cnt) == 2 * p_cur - 1) dp_cnt <= dp_cnt - 8'd1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vec = 8'h00;
            prev_scl = 1'b1;
        end else begin
            if (vec != prev_vec) begin
                obs_phase.push_back(vec);
                if (vec == V_WACK) ack_q.push_back(ack_bit);
                if (vec == V_WADDR && prev_vec == V_RS) waddr_rs_cnt = int'(cnt);
            end
            if (vec == V_RS) rs_obs.push_back({scl, cd});
            if (scl && !prev_scl && busy && !stop_s) n_rise++;
            if (busy) n_busy++;
            if (start_s) n_start++;
            if (dreq) begin n_dreq++; if (!(wdata_s && cnt == 8'd0)) n_dreq_bad++; end
            if (rdv)  begin n_rdv++;  if (!(wack_s && cnt == 8'd0))  n_rdv_bad++;  end
            if (done) n_done++;
            if ($countones(vec) > 1) n_multi++;
            prev_vec = vec;
            prev_scl = scl;
        end
    end

    task automatic clear_mon();
        n_rise = 0; n_busy = 0; n_start = 0; n_dreq = 0; n_dreq_bad = 0;
        n_rdv = 0; n_rdv_bad = 0; n_done = 0; n_multi = 0; waddr_rs_cnt = -1;
        obs_phase.delete(); exp_phase.delete(); ack_q.delete(); rs_obs.delete();
    endtask

    task automatic start_txn(input int p, input logic r, input logic [7:0] len, input logic rsi);
        @(negedge clk);
        prescaler = p[7:0]; p_cur = p; rw = r; length = len; rs = rsi; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done > 0) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (vec !== 8'h00) begin n_fail++; $display("FAIL rst_strobes got %h want 00", vec); end
        n_cmp++; if (cnt !== 8'd0 || cd !== 8'd0) begin n_fail++; $display("FAIL rst_counters got %0d/%0d want 0/0", cnt, cd); end
        n_cmp++; if (scl !== 1'b1) begin n_fail++; $display("FAIL rst_scl got %b want 1", scl); end
        n_cmp++; if ({ack_bit, busy, dreq, rdv, nack, done} !== 6'b0) begin
            n_fail++; $display("FAIL rst_flags got %b want 000000", {ack_bit, busy, dreq, rdv, nack, done}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_single();
        bit ok;
        logic [7:0] e, o;
        clear_mon(); sda = 1'b0;
        exp_phase = {V_START, V_WADDR, V_RACK, V_WDATA, V_RACK, V_STOP, V_IDLE};
        start_txn(4, 1'b0, 8'd1, 1'b0);
        prescaler = 8'd9;
        wait_done(400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr1_timeout got no done want done"); end
        n_cmp++; if (obs_phase.size() != exp_phase.size()) begin
            n_fail++; $display("FAIL wr1_phase_count got %0d want %0d", obs_phase.size(), exp_phase.size()); end
        while (exp_phase.size() > 0 && obs_phase.size() > 0) begin
            e = exp_phase.pop_front(); o = obs_phase.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL wr1_phase got %h want %h", o, e); end
        end
        n_cmp++; if (n_start != 4) begin n_fail++; $display("FAIL wr1_start_len got %0d want 4", n_start); end
        n_cmp++; if (n_rise != 18) begin n_fail++; $display("FAIL wr1_scl_rises got %0d want 18", n_rise); end
        n_cmp++; if (n_busy != 156) begin n_fail++; $display("FAIL wr1_busy_cycles got %0d want 156", n_busy); end
        n_cmp++; if (n_dreq != 1 || n_dreq_bad != 0) begin
            n_fail++; $display("FAIL wr1_data_req got %0d (bad %0d) want 1 (bad 0)", n_dreq, n_dreq_bad); end
        n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL wr1_done got %0d want 1", n_done); end
        n_cmp++; if (nack !== 1'b0) begin n_fail++; $display("FAIL wr1_nack got %b want 0", nack); end
        n_cmp++; if (n_multi != 0) begin n_fail++; $display("FAIL wr1_onehot got %0d want 0", n_multi); end
    endtask

    task automatic test_addr_nack();
        bit ok;
        logic [7:0] e, o;
        clear_mon(); sda = 1'b1;
        exp_phase = {V_START, V_WADDR, V_RACK, V_STOP, V_IDLE};
        start_txn(4, 1'b0, 8'd1, 1'b0);
        wait_done(400, ok);
        sda = 1'b0;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL nack_timeout got no done want done"); end
        n_cmp++; if (obs_phase.size() != exp_phase.size()) begin
            n_fail++; $display("FAIL nack_phase_count got %0d want %0d", obs_phase.size(), exp_phase.size()); end
        while (exp_phase.size() > 0 && obs_phase.size() > 0) begin
            e = exp_phase.pop_front(); o = obs_phase.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL nack_phase got %h want %h", o, e); end
        end
        n_cmp++; if (nack !== 1'b1) begin n_fail++; $display("FAIL nack_sticky got %b want 1", nack); end
        n_cmp++; if (n_dreq != 0) begin n_fail++; $display("FAIL nack_data_req got %0d want 0", n_dreq); end
        n_cmp++; if (n_busy != 84) begin n_fail++; $display("FAIL nack_busy_cycles got %0d want 84", n_busy); end
    endtask

    task automatic test_read_two();
        bit ok;
        logic [7:0] e, o;
        logic a;
        logic exp_ack[$];
        clear_mon(); sda = 1'b0;
        exp_phase = {V_START, V_WADDR, V_RACK, V_RDATA, V_WACK, V_RDATA, V_WACK, V_STOP, V_IDLE};
        exp_ack = {1'b0, 1'b1};
        start_txn(2, 1'b1, 8'd2, 1'b0);
        n_cmp++; if (nack !== 1'b0) begin n_fail++; $display("FAIL rd2_nack_clear got %b want 0", nack); end
        wait_done(300, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rd2_timeout got no done want done"); end
        n_cmp++; if (obs_phase.size() != exp_phase.size()) begin
            n_fail++; $display("FAIL rd2_phase_count got %0d want %0d", obs_phase.size(), exp_phase.size()); end
        while (exp_phase.size() > 0 && obs_phase.size() > 0) begin
            e = exp_phase.pop_front(); o = obs_phase.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL rd2_phase got %h want %h", o, e); end
        end
        n_cmp++; if (ack_q.size() != 2) begin n_fail++; $display("FAIL rd2_ack_count got %0d want 2", ack_q.size()); end
        while (exp_ack.size() > 0 && ack_q.size() > 0) begin
            a = exp_ack.pop_front(); o[0] = ack_q.pop_front();
            n_cmp++; if (o[0] !== a) begin n_fail++; $display("FAIL rd2_ack_bit got %b want %b", o[0], a); end
        end
        n_cmp++; if (n_rdv != 2 || n_rdv_bad != 0) begin
            n_fail++; $display("FAIL rd2_rd_valid got %0d (bad %0d) want 2 (bad 0)", n_rdv, n_rdv_bad); end
        n_cmp++; if (n_start != 2) begin n_fail++; $display("FAIL rd2_start_len got %0d want 2", n_start); end
        n_cmp++; if (n_busy != 114) begin n_fail++; $display("FAIL rd2_busy_cycles got %0d want 114", n_busy); end
    endtask

    task automatic test_repeat_start();
        bit ok, seen;
        logic [7:0] e, o;
        logic [8:0] re, ro;
        logic [8:0] exp_rs[$];
        clear_mon(); sda = 1'b0; seen = 1'b0;
        exp_phase = {V_START, V_WADDR, V_RACK, V_WDATA, V_RACK, V_RS,
                     V_WADDR, V_RACK, V_RDATA, V_WACK, V_STOP, V_IDLE};
        exp_rs = {9'h005, 9'h004, 9'h003, 9'h102, 9'h101, 9'h100};
        start_txn(3, 1'b0, 8'd1, 1'b1);
        rw = 1'b1; length = 8'd1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (vec == V_RS) begin seen = 1'b1; break; end
        end
        rs = 1'b0;
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rs_entry_timeout got none want REPEAT_START"); end
        wait_done(400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rs_timeout got no done want done"); end
        n_cmp++; if (obs_phase.size() != exp_phase.size()) begin
            n_fail++; $display("FAIL rs_phase_count got %0d want %0d", obs_phase.size(), exp_phase.size()); end
        while (exp_phase.size() > 0 && obs_phase.size() > 0) begin
            e = exp_phase.pop_front(); o = obs_phase.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL rs_phase got %h want %h", o, e); end
        end
        n_cmp++; if (rs_obs.size() != 6) begin n_fail++; $display("FAIL rs_countdown_len got %0d want 6", rs_obs.size()); end
        while (exp_rs.size() > 0 && rs_obs.size() > 0) begin
            re = exp_rs.pop_front(); ro = rs_obs.pop_front();
            n_cmp++; if (ro !== re) begin
                n_fail++; $display("FAIL rs_countdown got scl=%b cd=%0d want scl=%b cd=%0d", ro[8], ro[7:0], re[8], re[7:0]); end
        end
        n_cmp++; if (waddr_rs_cnt != 0) begin n_fail++; $display("FAIL rs_waddr_cnt got %0d want 0", waddr_rs_cnt); end
        n_cmp++; if (ack_q.size() != 1 || ack_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL rs_read_nack got %0d entries want 1 entry of 1", ack_q.size()); end
        n_cmp++; if (n_dreq != 1 || n_rdv != 1) begin
            n_fail++; $display("FAIL rs_pulses got dreq %0d rdv %0d want 1 1", n_dreq, n_rdv); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        logic [7:0] e, o;
        clear_mon(); sda = 1'b0; seen = 1'b0;
        start_txn(4, 1'b0, 8'd2, 1'b0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wdata_s && cnt == 8'd2) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL mid_reach_timeout got none want WRITE_DATA cnt 2"); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (vec !== 8'h00) begin n_fail++; $display("FAIL mid_rst_strobes got %h want 00", vec); end
        n_cmp++; if (cnt !== 8'd0 || cd !== 8'd0) begin n_fail++; $display("FAIL mid_rst_counters got %0d/%0d want 0/0", cnt, cd); end
        n_cmp++; if (scl !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_scl_busy got %b%b want 10", scl, busy); end
        n_cmp++; if ({ack_bit, dreq, rdv, nack, done} !== 5'b0) begin
            n_fail++; $display("FAIL mid_rst_flags got %b want 00000", {ack_bit, dreq, rdv, nack, done}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        exp_phase = {V_START, V_WADDR, V_RACK, V_WDATA, V_RACK, V_STOP, V_IDLE};
        start_txn(4, 1'b0, 8'd1, 1'b0);
        wait_done(400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_restart_timeout got no done want done"); end
        n_cmp++; if (obs_phase.size() != exp_phase.size()) begin
            n_fail++; $display("FAIL mid_phase_count got %0d want %0d", obs_phase.size(), exp_phase.size()); end
        while (exp_phase.size() > 0 && obs_phase.size() > 0) begin
            e = exp_phase.pop_front(); o = obs_phase.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL mid_phase got %h want %h", o, e); end
        end
        n_cmp++; if (n_busy != 156) begin n_fail++; $display("FAIL mid_busy_cycles got %0d want 156", n_busy); end
    endtask

    task automatic test_addr_only();
        bit ok;
        logic [7:0] e, o;
        clear_mon(); sda = 1'b0;
        exp_phase = {V_START, V_WADDR, V_RACK, V_STOP, V_IDLE};
        start_txn(4, 1'b0, 8'd0, 1'b0);
        wait_done(400, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL addr0_timeout got no done want done"); end
        n_cmp++; if (obs_phase.size() != exp_phase.size()) begin
            n_fail++; $display("FAIL addr0_phase_count got %0d want %0d", obs_phase.size(), exp_phase.size()); end
        while (exp_phase.size() > 0 && obs_phase.size() > 0) begin
            e = exp_phase.pop_front(); o = obs_phase.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL addr0_phase got %h want %h", o, e); end
        end
        n_cmp++; if (n_dreq != 0) begin n_fail++; $display("FAIL addr0_data_req got %0d want 0", n_dreq); end
        n_cmp++; if (nack !== 1'b0 || n_done != 1) begin
            n_fail++; $display("FAIL addr0_end got nack %b done %0d want 0 1", nack, n_done); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_write_single();
        test_addr_nack();
        test_read_two();
        test_repeat_start();
        test_reset_mid();
        test_addr_only();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
